// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage constants and next-PC select encoding
package mips_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [WORD_W-1:0] RESET_VEC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] TRAP_VEC  = 32'h0000_0080;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BRANCH,
        NPC_JUMP,
        NPC_RET,
        NPC_TRAP
    } npc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; oldest entry overwritten when full
//
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset (empties the stack)
//   push, push_data store push_data on top (never asserted together with pop)
//   pop             discard top entry (caller only pops a nonempty stack)
//   top             current top-of-stack value
//   empty           no valid entries
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic             full;

    // wr_ptr is the next free slot; the top lives one slot behind it.
    assign top_ptr = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1);
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // When full, a push lands on the oldest slot and count stays saturated.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            wr_ptr <= top_ptr;
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with trap/ret/jump/branch arbitration
//
// Optional feature macro: PC_RAS_EN (return-address stack; without it ret always
// takes the empty-stack path and jump_link is ignored).
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   enable              1 = PC may advance, 0 = stall (trap still taken)
//   trap_valid          load TRAP_VECTOR
//   ret_valid           load top of return stack
//   jump_valid/_link    load jump_target; with link, push pc_plus_inc
//   jump_target         jump destination
//   branch_taken        load branch_target
//   branch_target       branch destination
//   pc_out, pc_plus_inc current PC and PC + INC
//   pc_valid            PC is fetchable (set on first enabled edge after reset)
//   misalign_err        one-cycle pulse: loaded target had low bits set
//   ras_err             one-cycle pulse: return with empty stack
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int               WIDTH        = WORD_W,
    parameter int               INC          = INSTR_BYTES,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VEC),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(TRAP_VEC),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             trap_valid,
    input  logic             ret_valid,
    input  logic             jump_valid,
    input  logic             jump_link,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             pc_valid,
    output logic             misalign_err,
    output logic             ras_err
);

    // Bits below the instruction size must be zero in any fetch address.
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC - 1);

    npc_sel_e         npc_sel;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;

    assign pc_plus_inc = pc_out + WIDTH'(INC);

    // Trap overrides the stall; every other source needs enable.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (trap_valid) begin
            npc_sel = NPC_TRAP;
        end else if (enable) begin
            if (ret_valid) begin
                npc_sel = NPC_RET;
            end else if (jump_valid) begin
                npc_sel = NPC_JUMP;
            end else if (branch_taken) begin
                npc_sel = NPC_BRANCH;
            end
        end
    end

`ifdef PC_RAS_EN
    logic ras_push;
    logic ras_pop;

    assign ras_push = (npc_sel == NPC_JUMP) && jump_link;
    assign ras_pop  = (npc_sel == NPC_RET) && !ras_empty;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus_inc),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_jump_link;

    assign unused_jump_link = jump_link;
    assign ras_top          = '0;
    assign ras_empty        = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_out       <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            misalign_err <= 1'b0;
            ras_err      <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            ras_err      <= 1'b0;
            if (enable) begin
                pc_valid <= 1'b1;
            end
            case (npc_sel)
                NPC_TRAP: pc_out <= TRAP_VECTOR;
                NPC_RET: begin
                    if (ras_empty) begin
                        pc_out  <= pc_plus_inc;
                        ras_err <= 1'b1;
                    end else begin
                        pc_out <= ras_top;
                    end
                end
                NPC_JUMP: begin
                    pc_out       <= jump_target & ~LOW_MASK;
                    misalign_err <= |(jump_target & LOW_MASK);
                end
                NPC_BRANCH: begin
                    pc_out       <= branch_target & ~LOW_MASK;
                    misalign_err <= |(branch_target & LOW_MASK);
                end
                default: begin
                    if (enable) begin
                        pc_out <= pc_plus_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

`ifdef PC_RAS_EN
    localparam bit HAS_RAS = 1'b1;
`else
    localparam bit HAS_RAS = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        trap_valid = 1'b0;
    logic        ret_valid = 1'b0;
    logic        jump_valid = 1'b0;
    logic        jump_link = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_inc;
    logic        pc_valid;
    logic        misalign_err;
    logic        ras_err;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: PC as a plain number, return stack as a queue.
    logic [31:0] m_pc = 32'h0;
    bit          m_valid = 1'b0;
    bit          m_mis = 1'b0;
    bit          m_rerr = 1'b0;
    logic [31:0] m_stack[$];

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .trap_valid    (trap_valid),
        .ret_valid     (ret_valid),
        .jump_valid    (jump_valid),
        .jump_link     (jump_link),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .pc_plus_inc   (pc_plus_inc),
        .pc_valid      (pc_valid),
        .misalign_err  (misalign_err),
        .ras_err       (ras_err)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_rerr  = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_edge();
        m_mis  = 1'b0;
        m_rerr = 1'b0;
        if (enable) m_valid = 1'b1;
        if (trap_valid) begin
            m_pc = 32'h80;
        end else if (enable) begin
            if (ret_valid) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc   = m_pc + 4;
                    m_rerr = 1'b1;
                end
            end else if (jump_valid) begin
                if (HAS_RAS && jump_link) begin
                    m_stack.push_back(m_pc + 4);
                    if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
                end
                m_mis = (jump_target % 4) != 0;
                m_pc  = jump_target - (jump_target % 4);
            end else if (branch_taken) begin
                m_mis = (branch_target % 4) != 0;
                m_pc  = branch_target - (branch_target % 4);
            end else begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic drive(input bit en, input bit trap, input bit ret, input bit jv, input bit jl,
                         input logic [31:0] jt, input bit bt, input logic [31:0] btg);
        enable = en; trap_valid = trap; ret_valid = ret; jump_valid = jv; jump_link = jl;
        jump_target = jt; branch_taken = bt; branch_target = btg;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
        checks++;
        if ({pc_valid, misalign_err, ras_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {pc_valid, misalign_err, ras_err});
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 32'(4 * i);
            checks++;
            if (pc_out !== exp_pc || pc_valid !== 1'b1) begin
                errors++; $display("FAIL seq_after_reset step=%0d got=%h/%b exp=%h/1", i, pc_out, pc_valid, exp_pc);
            end
        end
    endtask

    task automatic test_stall_trap();
        drive(1, 0, 0, 1, 0, 32'h10, 0, 0);
        tick();
        drive(0, 0, 1, 1, 0, 32'h400, 1, 32'h500);
        repeat (2) begin
            tick();
            checks++;
            if (pc_out !== 32'h10 || pc_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold got=%h/%b exp=10/1", pc_out, pc_valid);
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc_out !== 32'h80) begin errors++; $display("FAIL trap_stalled got=%h exp=80", pc_out); end
    endtask

    task automatic test_priority_align();
        drive(1, 0, 0, 1, 0, 32'h200, 1, 32'h300);
        tick();
        checks++;
        if (pc_out !== 32'h200 || misalign_err !== 1'b0) begin
            errors++; $display("FAIL jump_over_branch got=%h/%b exp=200/0", pc_out, misalign_err);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 32'h302);
        tick();
        checks++;
        if (pc_out !== 32'h300 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL branch_misalign got=%h/%b exp=300/1", pc_out, misalign_err);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc_out !== 32'h304 || misalign_err !== 1'b0) begin
            errors++; $display("FAIL misalign_pulse_clear got=%h/%b exp=304/0", pc_out, misalign_err);
        end
        drive(1, 1, 1, 1, 0, 32'h203, 1, 32'h301);
        tick();
        checks++;
        if (pc_out !== 32'h80 || misalign_err !== 1'b0 || ras_err !== 1'b0) begin
            errors++; $display("FAIL trap_wins got=%h/%b/%b exp=80/0/0", pc_out, misalign_err, ras_err);
        end
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);
        tick();
        checks++;
        if (pc_plus_inc !== 32'h0) begin errors++; $display("FAIL plus_inc_wrap got=%h exp=0", pc_plus_inc); end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc_out !== 32'h0 || misalign_err !== 1'b0 || ras_err !== 1'b0) begin
            errors++; $display("FAIL pc_wrap got=%h/%b/%b exp=0/0/0", pc_out, misalign_err, ras_err);
        end
    endtask

    task automatic test_ras();
        logic [31:0] exp_pc;
        bit          exp_err;
        drive(1, 0, 0, 1, 0, 32'h10, 0, 0);
        tick();
        for (int i = 2; i <= 6; i++) begin
            drive(1, 0, 0, 1, 1, 32'(16 * i), 0, 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 0, 0, 0, 0);
            tick();
            if (i < 4) begin
                exp_pc  = HAS_RAS ? 32'(32'h54 - 16 * i) : 32'(32'h64 + 4 * i);
                exp_err = !HAS_RAS;
            end else begin
                exp_pc  = HAS_RAS ? 32'h28 : 32'h74;
                exp_err = 1'b1;
            end
            checks++;
            if (pc_out !== exp_pc || ras_err !== exp_err) begin
                errors++; $display("FAIL ret_seq idx=%0d got=%h/%b exp=%h/%b", i, pc_out, ras_err, exp_pc, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid_stack();
        drive(1, 0, 0, 1, 1, 32'h100, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%h/%b exp=0/0", pc_out, pc_valid);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc_out !== 32'h4 || ras_err !== 1'b1) begin
            errors++; $display("FAIL ret_after_reset got=%h/%b exp=4/1", pc_out, ras_err);
        end
    endtask

    task automatic test_random();
        logic [31:0] jt;
        logic [31:0] bt;
        for (int n = 0; n < 400; n++) begin
            jt = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
            bt = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, jt,
                  $urandom_range(0, 3) == 0, bt);
            tick();
            checks++;
            if (pc_out !== m_pc || pc_plus_inc !== m_pc + 32'd4 || pc_valid !== m_valid ||
                misalign_err !== m_mis || ras_err !== m_rerr) begin
                errors++;
                $display("FAIL random cyc=%0d got pc=%h inc=%h v=%b mis=%b rerr=%b exp pc=%h inc=%h v=%b mis=%b rerr=%b",
                         n, pc_out, pc_plus_inc, pc_valid, misalign_err, ras_err,
                         m_pc, m_pc + 32'd4, m_valid, m_mis, m_rerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall_trap();
        test_priority_align();
        test_wrap();
        test_ras();
        test_reset_mid_stack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
